par_serial_tx: RTL and testbench

PAR_SERIAL_TX -- requirements
Module: par_serial_tx

---
 rtl/phy_tx_pkg.sv | 12 +
 rtl/par_serial_tx.sv | 67 ++++++
 tb/tb_par_serial_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY byte serializer and the paired receive-side deserializer.
package phy_tx_pkg;

    localparam logic [7:0] COM_BYTE  = 8'hBC;
    localparam logic [7:0] IDLE_BYTE = 8'h7C;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

endpackage

// File: rtl/par_serial_tx.sv
// Byte-to-serial transmitter: sends SYNC_COUNT COM bytes after reset, then payload or IDLE bytes MSB first.
//
// state  | meaning
// SYNC   | sending the post-reset COM preamble; valid_in ignored
// ACTIVE | each byte slot carries data_in when valid_in, otherwise IDLE
module par_serial_tx
    import phy_tx_pkg::*;
#(
    parameter int SYNC_COUNT = 4
) (
    input  logic       clk_16f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       data_out,
    output logic       active,
    output logic       byte_tick
);

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] sync_cnt;
    logic [3:0] sync_cnt_next;
    tx_state_t  state;
    tx_state_t  state_next;
    logic [7:0] next_byte;
    logic       load;

    assign load      = (bit_cnt == 3'd7);
    assign byte_tick = load && !reset;

    always_comb begin
        state_next    = state;
        sync_cnt_next = sync_cnt;
        next_byte     = valid_in ? data_in : IDLE_BYTE;
        if (load && state == SYNC) begin
            if (sync_cnt < SYNC_LAST) begin
                next_byte     = COM_BYTE;
                sync_cnt_next = sync_cnt + 4'd1;
            end else begin
                // Last preamble slot: this same edge already picks the first payload/idle byte.
                state_next = ACTIVE;
            end
        end
    end

    always_ff @(posedge clk_16f) begin
        if (reset) begin
            sr       <= COM_BYTE;
            bit_cnt  <= 3'd0;
            sync_cnt <= 4'd0;
            state    <= SYNC;
            data_out <= 1'b0;
            active   <= 1'b0;
        end else begin
            data_out <= sr[7];
            bit_cnt  <= bit_cnt + 3'd1;
            sr       <= load ? next_byte : {sr[6:0], 1'b0};
            sync_cnt <= sync_cnt_next;
            state    <= state_next;
            active   <= (state_next == ACTIVE);
        end
    end

endmodule

// File: tb/tb_par_serial_tx.sv
// Bench for par_serial_tx: byte-slot scoreboard for SYNC_COUNT=4 and 1, table vectors and directed corner sequences.
module tb_par_serial_tx;

    logic       clk_16f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out4, active4, byte_tick4;
    logic       data_out1, active1, byte_tick1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_16f = ~clk_16f;

    par_serial_tx #(.SYNC_COUNT(4)) dut4 (
        .clk_16f(clk_16f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out4), .active(active4), .byte_tick(byte_tick4)
    );

    par_serial_tx #(.SYNC_COUNT(1)) dut1 (
        .clk_16f(clk_16f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out1), .active(active1), .byte_tick(byte_tick1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: time is counted in edges since reset; byte slot n occupies edges 8n+1..8n+8
    // and its content is decided at edge 8n (COM for the first S slots, else sampled input).
    task automatic model_step(input int s, inout int t, inout logic [7:0] cur,
                              output logic eo, output logic et, output logic ea);
        if (reset) begin
            t   = 0;
            cur = 8'hBC;
            eo  = 1'b0;
        end else if (t >= 0) begin
            t++;
            eo = cur[3'(7 - ((t - 1) % 8))];
            if (t % 8 == 0)
                cur = (t / 8 < s) ? 8'hBC : (valid_in ? data_in : 8'h7C);
        end else begin
            eo = 1'b0;
        end
        et = !reset && (t >= 0) && (t % 8 == 7);
        ea = (t >= 8 * s);
    endtask

    int         t4 = -1, t1 = -1;
    logic [7:0] cur4, cur1;
    logic       eo4, et4, ea4, eo1, et1, ea1;

    always @(posedge clk_16f) begin
        model_step(4, t4, cur4, eo4, et4, ea4);
        model_step(1, t1, cur1, eo1, et1, ea1);
        #1;
        if (t4 >= 0) begin
            check("sb_data4",   {7'd0, data_out4},  {7'd0, eo4});
            check("sb_tick4",   {7'd0, byte_tick4}, {7'd0, et4});
            check("sb_active4", {7'd0, active4},    {7'd0, ea4});
            check("sb_data1",   {7'd0, data_out1},  {7'd0, eo1});
            check("sb_tick1",   {7'd0, byte_tick1}, {7'd0, et1});
            check("sb_active1", {7'd0, active1},    {7'd0, ea1});
        end
    end

    // Holds reset for n edges, checks the reset outputs, then releases just after the last reset edge.
    task automatic do_reset(input int n);
        @(negedge clk_16f);
        reset = 1'b1;
        repeat (n) @(posedge clk_16f);
        #1;
        check("rst_data",   {7'd0, data_out4},  8'd0);
        check("rst_active", {7'd0, active4},    8'd0);
        check("rst_tick",   {7'd0, byte_tick4}, 8'd0);
        #1;
        reset = 1'b0;
    endtask

    // Collects one 8-edge byte slot from both DUTs; with junk set, the first half of the slot
    // carries random inputs so only the values present at byte_tick may matter.
    task automatic capture(output logic [7:0] b4, output logic [7:0] b1,
                           input bit junk, input logic v, input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_16f);
            if (junk && i < 4) begin
                valid_in = 1'($urandom);
                data_in  = 8'($urandom);
            end else begin
                valid_in = v;
                data_in  = d;
            end
            @(posedge clk_16f);
            #1;
            b4[7-i] = data_out4;
            b1[7-i] = data_out1;
            if (i == 6) check("tick_phase", {7'd0, byte_tick4}, 8'd1);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [7:0] exp;
        bit         junk;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] b4, b1;
    logic [3:0] hi;

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h7C, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 8'h00, 1'b1};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[4] = '{1'b1, 8'h81, 8'h81, 1'b1};
        vecs[5] = '{1'b0, 8'h55, 8'h7C, 1'b1};
        vecs[6] = '{1'b1, 8'h3C, 8'h3C, 1'b1};

        // Power-up preamble with no traffic.
        do_reset(3);
        for (int k = 0; k < 6; k++) begin
            capture(b4, b1, 1'b0, 1'b0, 8'h00);
            check("pre_byte4", b4, (k < 4) ? 8'hBC : 8'h7C);
            check("pre_byte1", b1, (k < 1) ? 8'hBC : 8'h7C);
            check("pre_active4", {7'd0, active4}, (k >= 3) ? 8'd1 : 8'd0);
            check("pre_active1", {7'd0, active1}, 8'd1);
        end

        // Table vectors; each result appears one slot after its inputs are applied.
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) capture(b4, b1, vecs[i].junk, vecs[i].v, vecs[i].d);
            else       capture(b4, b1, 1'b0, 1'b0, 8'h00);
            if (i > 0) begin
                check("vec_byte4", b4, vecs[i-1].exp);
                check("vec_byte1", b1, vecs[i-1].exp);
            end
        end

        // Valid bytes offered during the preamble must be dropped.
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            capture(b4, b1, 1'b0, (k < 3) ? 1'b1 : 1'b0, 8'h55);
            check("sync_drop_byte4", b4, (k < 4) ? 8'hBC : 8'h7C);
        end

        // Reset pulse while payload 0xC3 is mid-shift restarts the preamble.
        capture(b4, b1, 1'b0, 1'b1, 8'hC3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_16f);
            valid_in = 1'b0;
            @(posedge clk_16f);
            #1;
            hi[3-i] = data_out4;
        end
        check("c3_upper_bits", {4'd0, hi}, 8'h0C);
        @(negedge clk_16f);
        reset = 1'b1;
        @(posedge clk_16f);
        #1;
        check("abort_data",   {7'd0, data_out4}, 8'd0);
        check("abort_active", {7'd0, active4},   8'd0);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            capture(b4, b1, 1'b0, 1'b0, 8'h00);
            check("restart_byte4", b4, (k < 4) ? 8'hBC : 8'h7C);
            check("restart_active4", {7'd0, active4}, (k >= 3) ? 8'd1 : 8'd0);
        end

        // Random traffic with occasional resets, judged by the scoreboard.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_16f);
            valid_in = 1'($urandom);
            data_in  = 8'($urandom);
            reset    = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk_16f);
        reset = 1'b0;
        repeat (4) @(posedge clk_16f);
        #2;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
